// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, config field codes and colour types for the
// rectangle compositor.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int COORD_W    = 10;
  localparam int CFG_DATA_W = 16;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
  localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t V_SYNC_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t H_VIS        = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS        = coord_t'(V_ACTIVE);

  typedef enum logic [2:0] {
    F_X0     = 3'd0,
    F_Y0     = 3'd1,
    F_X1     = 3'd2,
    F_Y1     = 3'd3,
    F_COLOR  = 3'd4,
    F_EN     = 3'd5,
    F_COMMIT = 3'd6,
    F_RSVD   = 3'd7
  } cfg_field_e;

  localparam int DEF_COLOR_W = 4;
  typedef logic [3*DEF_COLOR_W-1:0] rgb_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, h/v raster counters, raw sync/de and the commit-point strobe
// (the pixel enable on which the counters sit at h=0, v=480).
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic   clk,
  input  logic   rst,
  output logic   pix_ce,
  output coord_t h,
  output coord_t v,
  output logic   de,
  output logic   h_sync,
  output logic   v_sync,
  output logic   commit
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else if (pix_ce) begin
      div <= '0;
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  assign pix_ce = (div == DIV_LAST);
  assign de     = (h < H_VIS) && (v < V_VIS);
  assign h_sync = !((h >= H_SYNC_START) && (h < H_SYNC_END));
  assign v_sync = !((v >= V_SYNC_START) && (v < V_SYNC_END));
  assign commit = pix_ce && (h == '0) && (v == V_VIS);

endmodule

// File: rtl/vga_rect_compositor.sv
// VGA frame generator with NUM_RECTS programmable filled rectangles, shadow/active
// register file committed at the start of vertical blanking. Optional: RECT_BLINK_EN.
module vga_rect_compositor
  import vga_pkg::*;
#(
  parameter int NUM_RECTS = 4,
  parameter int COLOR_W   = 4,
  parameter int CLK_DIV   = 2,
  parameter logic [3*COLOR_W-1:0] BG_COLOR = '0,
  localparam int IDX_W = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [2:0]            cfg_field,
  input  logic [CFG_DATA_W-1:0] cfg_data,
  output logic                  h_sync,
  output logic                  v_sync,
  output logic                  de,
  output logic                  frame_start,
  output logic [COLOR_W-1:0]    r_out,
  output logic [COLOR_W-1:0]    g_out,
  output logic [COLOR_W-1:0]    b_out
);

  localparam int RGB_W = 3 * COLOR_W;

  typedef struct packed {
    coord_t           x0;
    coord_t           y0;
    coord_t           x1;
    coord_t           y1;
    logic [RGB_W-1:0] color;
    logic             en;
  } slot_t;

  logic       pix_ce, de_raw, hs_raw, vs_raw, commit;
  coord_t     h, v;
  slot_t      shadow [NUM_RECTS];
  slot_t      active [NUM_RECTS];
  logic       pending;
  logic       accept, idx_ok, data_unused;
  cfg_field_e field;
  logic [RGB_W-1:0] pix_color;

  vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk    (clk),
    .rst    (rst),
    .pix_ce (pix_ce),
    .h      (h),
    .v      (v),
    .de     (de_raw),
    .h_sync (hs_raw),
    .v_sync (vs_raw),
    .commit (commit)
  );

  // Ready drops only in the commit cycle, so a write can never race the shadow->active copy.
  assign cfg_ready   = !commit;
  assign accept      = cfg_valid && cfg_ready;
  assign field       = cfg_field_e'(cfg_field);
  assign idx_ok      = (int'(cfg_idx) < NUM_RECTS);
  assign data_unused = ^cfg_data;

`ifdef RECT_BLINK_EN
  logic [NUM_RECTS-1:0] blink_sh, blink_act;
  logic [5:0]           frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) frame_cnt <= '0;
    else if (commit) frame_cnt <= frame_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_RECTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
`ifdef RECT_BLINK_EN
      blink_sh  <= '0;
      blink_act <= '0;
`endif
      pending <= 1'b0;
    end else if (commit) begin
      if (pending) begin
        for (int unsigned i = 0; i < NUM_RECTS; i++) active[i] <= shadow[i];
`ifdef RECT_BLINK_EN
        blink_act <= blink_sh;
`endif
      end
      pending <= 1'b0;
    end else if (accept) begin
      if (field == F_COMMIT) begin
        pending <= 1'b1;
      end else if (idx_ok) begin
        case (field)
          F_X0:    shadow[cfg_idx].x0    <= cfg_data[COORD_W-1:0];
          F_Y0:    shadow[cfg_idx].y0    <= cfg_data[COORD_W-1:0];
          F_X1:    shadow[cfg_idx].x1    <= cfg_data[COORD_W-1:0];
          F_Y1:    shadow[cfg_idx].y1    <= cfg_data[COORD_W-1:0];
          F_COLOR: shadow[cfg_idx].color <= cfg_data[RGB_W-1:0];
          F_EN: begin
            shadow[cfg_idx].en <= cfg_data[0];
`ifdef RECT_BLINK_EN
            blink_sh[cfg_idx] <= cfg_data[1];
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Ascending scan with a found flag gives lowest-index priority.
  always_comb begin
    logic hit;
    logic vis;
    hit       = 1'b0;
    pix_color = BG_COLOR;
    for (int unsigned i = 0; i < NUM_RECTS; i++) begin
`ifdef RECT_BLINK_EN
      vis = active[i].en && !(blink_act[i] && frame_cnt[5]);
`else
      vis = active[i].en;
`endif
      if (!hit && vis &&
          (h >= active[i].x0) && (h < active[i].x1) &&
          (v >= active[i].y0) && (v < active[i].y1)) begin
        hit       = 1'b1;
        pix_color = active[i].color;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      de          <= 1'b0;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= commit;
      if (pix_ce) begin
        h_sync <= hs_raw;
        v_sync <= vs_raw;
        de     <= de_raw;
        {r_out, g_out, b_out} <= de_raw ? pix_color : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_rect_compositor.sv
// Scoreboard bench: expected pixels (by frame/x/y) are queued up front, a negedge monitor
// pops and compares each one when the displayed pixel index reaches it.
`timescale 1ns/1ps
module tb_vga_rect_compositor;

  localparam int NR    = 5;
  localparam int CW    = 4;
  localparam int DIV   = 2;
  localparam int LINE  = 800;
  localparam int FRAME = 800 * 525;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_idx = '0;
  logic [2:0]  cfg_field = '0;
  logic [15:0] cfg_data = '0;
  logic        h_sync, v_sync, de, frame_start;
  logic [CW-1:0] r_out, g_out, b_out;

  vga_rect_compositor #(
    .NUM_RECTS(NR),
    .COLOR_W  (CW),
    .CLK_DIV  (DIV),
    .BG_COLOR (12'h000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_idx    (cfg_idx),
    .cfg_field  (cfg_field),
    .cfg_data   (cfg_data),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .de         (de),
    .frame_start(frame_start),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          p;
    logic [11:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks = 0;
  int    errors = 0;
  int    k = 0;
  int    de_cnt0 = 0, hs_low_l0 = 0, vs_low_f0 = 0, rdy_low = 0, fs_cnt = 0;

  // Non-reset edges since reset release; displayed pixel index lags by one pixel enable.
  always @(posedge clk) k <= rst ? 0 : k + 1;

  function automatic int cur_p();
    return (k < 2) ? -1 : (k - 2) / DIV;
  endfunction

  function automatic int pix(input int f, input int x, input int y);
    return f * FRAME + y * LINE + x;
  endfunction

  task automatic push_raw(input string nm, input int p, input logic [11:0] rgb,
                          input logic de_e, input logic hs_e, input logic vs_e);
    exp_t e;
    e.p = p; e.rgb = rgb; e.de = de_e; e.hs = hs_e; e.vs = vs_e;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic px(input string nm, input int f, input int x, input int y,
                    input logic [11:0] rgb, input logic de_e, input logic hs_e, input logic vs_e);
    push_raw(nm, pix(f, x, y), rgb, de_e, hs_e, vs_e);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  // Monitor: statistics plus scoreboard pops.
  initial begin
    exp_t  e;
    string nm;
    int    p;
    forever begin
      @(negedge clk);
      p = cur_p();
      if (!rst) begin
        if (!cfg_ready) rdy_low++;
        if (frame_start) fs_cnt++;
        if (k >= 2 && ((k - 2) % DIV) == 0 && p < FRAME) begin
          if (de) de_cnt0++;
          if (!v_sync) vs_low_f0++;
          if (p < LINE && !h_sync) hs_low_l0++;
        end
      end
      while (q.size() > 0 && q[0].p <= p) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        checks++;
        if (e.p < p) begin
          errors++;
          $display("FAIL %s: pixel %0d passed before compare (now %0d)", nm, e.p, p);
        end else if ({r_out, g_out, b_out} !== e.rgb || de !== e.de || h_sync !== e.hs ||
                     v_sync !== e.vs || frame_start !== 1'b0 || cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s: got rgb=%h de=%b hs=%b vs=%b fs=%b rdy=%b, expected rgb=%h de=%b hs=%b vs=%b fs=0 rdy=1",
                   nm, {r_out, g_out, b_out}, de, h_sync, v_sync, frame_start, cfg_ready,
                   e.rgb, e.de, e.hs, e.vs);
        end
      end
    end
  end

  task automatic cfg_write(input logic [2:0] idx, input logic [2:0] fld, input logic [15:0] data);
    int n;
    n = 0;
    cfg_idx = idx; cfg_field = fld; cfg_data = data; cfg_valid = 1'b1;
    while (!cfg_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL cfg_handshake: ready stuck low, expected high");
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic rect(input logic [2:0] idx, input int x0, input int y0, input int x1,
                      input int y1, input logic [11:0] col);
    cfg_write(idx, 3'd0, 16'(x0));
    cfg_write(idx, 3'd1, 16'(y0));
    cfg_write(idx, 3'd2, 16'(x1));
    cfg_write(idx, 3'd3, 16'(y1));
    cfg_write(idx, 3'd4, {4'h0, col});
    cfg_write(idx, 3'd5, 16'h0001);
  endtask

  task automatic wait_pix(input int p);
    int n;
    n = 0;
    while (cur_p() < p && n < 2_000_000) begin
      @(negedge clk);
      n++;
    end
    if (cur_p() < p) begin
      $display("FAIL wait_pix: reached %0d, expected %0d", cur_p(), p);
      $fatal(1);
    end
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state and frame 0 timing boundaries.
    push_raw("reset",     -1,             12'h000, 1'b0, 1'b1, 1'b1);
    px("f0_origin",     0,   0,   0, 12'h000, 1'b1, 1'b1, 1'b1);
    px("de_last",       0, 639,   0, 12'h000, 1'b1, 1'b1, 1'b1);
    px("de_off",        0, 640,   0, 12'h000, 1'b0, 1'b1, 1'b1);
    px("hs_before",     0, 655,   0, 12'h000, 1'b0, 1'b1, 1'b1);
    px("hs_first",      0, 656,   0, 12'h000, 1'b0, 1'b0, 1'b1);
    px("hs_last",       0, 751,   0, 12'h000, 1'b0, 1'b0, 1'b1);
    px("hs_after",      0, 752,   0, 12'h000, 1'b0, 1'b1, 1'b1);
    px("f0_uncommit",   0,  10,  20, 12'h000, 1'b1, 1'b1, 1'b1);
    px("f0_mid_write",  0, 210, 250, 12'h000, 1'b1, 1'b1, 1'b1);
    px("f0_mid_write2", 0, 260, 260, 12'h000, 1'b1, 1'b1, 1'b1);
    px("f0_last_line",  0, 600, 479, 12'h000, 1'b1, 1'b1, 1'b1);
    px("vblank",        0,   5, 480, 12'h000, 1'b0, 1'b1, 1'b1);
    px("vs_before",     0,   0, 489, 12'h000, 1'b0, 1'b1, 1'b1);
    px("vs_first",      0,   0, 490, 12'h000, 1'b0, 1'b1, 1'b0);
    px("vs_last",       0, 799, 491, 12'h000, 1'b0, 1'b1, 1'b0);
    px("vs_after",      0,   0, 492, 12'h000, 1'b0, 1'b1, 1'b1);
    // Frame 1: everything committed at the frame 0 blanking point.
    px("s4_left_out",   1, 599,   0, 12'h000, 1'b1, 1'b1, 1'b1);
    px("s4_line0",      1, 600,   0, 12'hFF0, 1'b1, 1'b1, 1'b1);
    px("s4_right",      1, 639,   0, 12'hFF0, 1'b1, 1'b1, 1'b1);
    px("s4_y1_out",     1, 600,   1, 12'h000, 1'b1, 1'b1, 1'b1);
    px("empty_rect",    1,  50,  10, 12'h000, 1'b1, 1'b1, 1'b1);
    px("s0_x0_minus",   1,   9,  20, 12'h000, 1'b1, 1'b1, 1'b1);
    px("s0_corner",     1,  10,  20, 12'hF00, 1'b1, 1'b1, 1'b1);
    px("s0_x1_out",     1,  30,  20, 12'h000, 1'b1, 1'b1, 1'b1);
    px("s0_far",        1,  29,  39, 12'hF00, 1'b1, 1'b1, 1'b1);
    px("s0_y1_out",     1,  10,  40, 12'h000, 1'b1, 1'b1, 1'b1);
    px("s1_top",        1, 210, 200, 12'h0F0, 1'b1, 1'b1, 1'b1);
    px("s1_only",       1, 210, 250, 12'h0F0, 1'b1, 1'b1, 1'b1);
    px("overlap_low",   1, 260, 260, 12'h0F0, 1'b1, 1'b1, 1'b1);
    px("overlap_edge",  1, 299, 299, 12'h0F0, 1'b1, 1'b1, 1'b1);
    px("s2_after_s1",   1, 300, 299, 12'h00F, 1'b1, 1'b1, 1'b1);
    px("s2_last_act",   1, 639, 300, 12'h00F, 1'b1, 1'b1, 1'b1);
    px("s2_in_blank",   1, 650, 300, 12'h000, 1'b0, 1'b1, 1'b1);
    px("s2_only",       1, 320, 320, 12'h00F, 1'b1, 1'b1, 1'b1);
    px("s2_y_last",     1, 320, 349, 12'h00F, 1'b1, 1'b1, 1'b1);
    px("s2_y1_out",     1, 320, 350, 12'h000, 1'b1, 1'b1, 1'b1);

    repeat (4) @(negedge clk);
    rst = 1'b0;

    rect(3'd0, 10, 20, 30, 40, 12'hF00);
    rect(3'd2, 250, 250, 700, 350, 12'h00F);
    rect(3'd3, 50, 0, 50, 480, 12'hFFF);
    rect(3'd5, 0, 0, 640, 480, 12'hFFF);
    cfg_write(3'd0, 3'd7, 16'hFFFF);
    cfg_write(3'd0, 3'd6, 16'h0000);
    cfg_write(3'd1, 3'd6, 16'h0000);

    // Mid-frame writes plus commit: frame 0 must stay untouched.
    wait_pix(pix(0, 0, 205));
    rect(3'd1, 200, 200, 300, 300, 12'h0F0);
    rect(3'd4, 600, 0, 640, 1, 12'hFF0);
    cfg_write(3'd0, 3'd6, 16'h0000);

    wait_pix(pix(1, 321, 350));
    chk("queue_drained", q.size(), 0);
    chk("de_pixels_f0", de_cnt0, 640 * 480);
    chk("hs_low_line0", hs_low_l0, 96);
    chk("vs_low_f0", vs_low_f0, 2 * 800);
    chk("ready_low_clks", rdy_low, 1);
    chk("frame_start_clks", fs_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
